// File: rtl/rv_mc_core.sv
// Multi-cycle RV32I/E subset core: one fetch cycle (stretched by imem_ready) and one execute cycle per instruction.
// Traps and EBREAK park the core in HALT until reset.
module rv_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          NREG     = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic        illegal
);

    localparam int          AW     = (NREG == 16) ? 4 : 5;
    localparam logic [5:0]  NREG_L = 6'(NREG);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [31:0] EBREAK_W = 32'h00100073;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_ir;
    logic        r_halted, r_illegal;
    logic [31:0] r_regs [NREG];

    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_u, w_imm_j, w_imm_b;
    logic [31:0] w_rs1_val, w_rs2_val, w_op_b, w_alu;
    logic [31:0] w_rd_val, w_target, w_next_pc;
    logic        w_legal, w_use_rs1, w_use_rs2, w_use_rd, w_wr_en;
    logic        w_jump, w_br_taken, w_ebreak, w_bad_idx, w_misalign, w_trap;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_u = {r_ir[31:12], 12'b0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    // Indices beyond NREG read as zero here; the trap check stops them from committing.
    assign w_rs1_val = (w_rs1 == 5'd0 || {1'b0, w_rs1} >= NREG_L) ? 32'd0 : r_regs[w_rs1[AW-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0 || {1'b0, w_rs2} >= NREG_L) ? 32'd0 : r_regs[w_rs2[AW-1:0]];

    assign w_op_b = (w_opcode == OP_REG) ? w_rs2_val : w_imm_i;

    always_comb begin
        w_alu = 32'd0;
        case (w_f3)
            3'b000: w_alu = (w_opcode == OP_REG && w_f7[5]) ? w_rs1_val - w_op_b : w_rs1_val + w_op_b;
            3'b010: w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_op_b)};
            3'b011: w_alu = {31'd0, w_rs1_val < w_op_b};
            3'b100: w_alu = w_rs1_val ^ w_op_b;
            3'b110: w_alu = w_rs1_val | w_op_b;
            3'b111: w_alu = w_rs1_val & w_op_b;
            default: w_alu = 32'd0;
        endcase
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (w_f3)
            3'b000: w_br_taken = (w_rs1_val == w_rs2_val);
            3'b001: w_br_taken = (w_rs1_val != w_rs2_val);
            3'b100: w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101: w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110: w_br_taken = (w_rs1_val <  w_rs2_val);
            3'b111: w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_wr_en   = 1'b0;
        w_rd_val  = 32'd0;
        w_jump    = 1'b0;
        w_target  = r_pc + 32'd4;
        w_ebreak  = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                w_legal   = (w_f3 != 3'b001) && (w_f3 != 3'b101);
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_wr_en   = 1'b1;
                w_rd_val  = w_alu;
            end
            OP_REG: begin
                w_legal   = (w_f7 == 7'b0000000 && w_f3 != 3'b001 && w_f3 != 3'b101)
                         || (w_f7 == 7'b0100000 && w_f3 == 3'b000);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_wr_en   = 1'b1;
                w_rd_val  = w_alu;
            end
            OP_LUI, OP_AUI: begin
                w_legal  = 1'b1;
                w_use_rd = 1'b1;
                w_wr_en  = 1'b1;
                w_rd_val = (w_opcode == OP_LUI) ? w_imm_u : r_pc + w_imm_u;
            end
            OP_JAL: begin
                w_legal  = 1'b1;
                w_use_rd = 1'b1;
                w_wr_en  = 1'b1;
                w_rd_val = r_pc + 32'd4;
                w_jump   = 1'b1;
                w_target = r_pc + w_imm_j;
            end
            OP_JLR: begin
                w_legal   = (w_f3 == 3'b000);
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_wr_en   = 1'b1;
                w_rd_val  = r_pc + 32'd4;
                w_jump    = 1'b1;
                w_target  = (w_rs1_val + w_imm_i) & 32'hFFFF_FFFE;
            end
            OP_BR: begin
                w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_jump    = w_br_taken;
                w_target  = w_br_taken ? r_pc + w_imm_b : r_pc + 32'd4;
            end
            OP_SYS: begin
                w_legal  = (r_ir == EBREAK_W);
                w_ebreak = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_bad_idx  = (w_use_rs1 && {1'b0, w_rs1} >= NREG_L)
                     || (w_use_rs2 && {1'b0, w_rs2} >= NREG_L)
                     || (w_use_rd  && {1'b0, w_rd}  >= NREG_L);
    assign w_misalign = w_jump && (w_target[1:0] != 2'b00);
    assign w_trap     = !w_legal || w_bad_idx || w_misalign;
    assign w_next_pc  = w_target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_trap) begin
                    w_state_nxt = S_HALT;
                end else begin
                    retire      = 1'b1;
                    w_state_nxt = w_ebreak ? S_HALT : S_FETCH;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= 32'd0;
        end else begin
            if (r_state == S_FETCH && imem_ready) r_ir <= imem_rdata;
            if (r_state == S_EXEC) begin
                if (w_trap) begin
                    r_halted  <= 1'b1;
                    r_illegal <= 1'b1;
                end else begin
                    if (w_ebreak) r_halted <= 1'b1;
                    else          r_pc     <= w_next_pc;
                    if (w_wr_en && w_rd != 5'd0) r_regs[w_rd[AW-1:0]] <= w_rd_val;
                end
            end
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

endmodule

// File: doc/rv_mc_core.md
RV_MC_CORE -- requirements
Module: rv_mc_core

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h80000000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter NREG, default 32, giving the architectural register count; legal values are 16 (RV32E) and 32.
REQ-003 The block SHALL have clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have imem_req  output  1  instruction fetch request.
REQ-006 The block SHALL have imem_addr  output  32  fetch address, always equal to pc.
REQ-007 The block SHALL have imem_ready  input  1  fetch accepted; imem_rdata valid this cycle.
REQ-008 The block SHALL have imem_rdata  input  32  fetched instruction word.
REQ-009 The block SHALL have pc  output  32  current program counter.
REQ-010 The block SHALL have retire  output  1  one-cycle pulse when an instruction completes.
REQ-011 The block SHALL have halted  output  1  sticky; core stopped by EBREAK or a trap.
REQ-012 The block SHALL have illegal  output  1  sticky; the halt was caused by a trap.

Function
REQ-013 The core SHALL use a three-state FSM: FETCH, EXEC, HALT.
REQ-014 In FETCH: imem_req=1. When imem_ready=1 the core SHALL latch imem_rdata into the instruction register and enter EXEC the next cycle. While imem_ready=0 it SHALL hold FETCH with pc stable.
REQ-015 In EXEC: imem_req=0. The core SHALL decode the instruction, write rd, update pc and pulse retire for exactly one cycle, then return to FETCH. Minimum cost is 2 cycles per instruction.
REQ-016 Supported instructions SHALL be: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, ADD, SUB, AND, OR, XOR, SLT, SLTU, LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, EBREAK.
REQ-017 Immediates SHALL be sign-extended to 32 bits using standard RV32I I/U/J/B encodings. Arithmetic SHALL be modulo 2^32.
REQ-018 JAL and JALR SHALL write pc+4 to rd. The JALR target SHALL be (rs1+imm) with bit 0 cleared. The branch target SHALL be pc+imm when taken and pc+4 otherwise.
REQ-019 Register x0 SHALL read as 0, and writes to it SHALL be discarded. A read and a write of the same register in EXEC SHALL return the old value.
REQ-020 A trap (illegal=1, halted=1, HALT state, no retire, pc unchanged) SHALL occur on any of the following:
- unsupported opcode or funct encoding;
- rs1, rs2 or rd index >= NREG;
- taken jump or branch target with bits[1:0] != 0.
No register is written on a trap.
REQ-021 EBREAK SHALL pulse retire, set halted=1, leave illegal=0, keep pc at the EBREAK address, and enter HALT.
REQ-022 HALT SHALL be absorbing until reset: imem_req=0, retire=0, no state changes.

Reset
REQ-023 Reset assertion SHALL immediately (asynchronously) force:
- state=FETCH, pc=RESET_PC;
- retire=0, halted=0, illegal=0;
- all registers cleared to 0.
REQ-024 Reset asserted mid-fetch or in EXEC SHALL abort the instruction with no register write. The first request after deassertion SHALL be to RESET_PC.

Verification
REQ-025 Scenario 1 SHALL check that, after reset release, imem_req=1 with imem_addr=32'h80000000 on the first cycle.
REQ-026 Scenario 2 (ADDI with negative immediate): ADDI x1,x0,-1 then ADDI x2,x1,2 -> x1=32'hFFFFFFFF, x2=1, two retire pulses, pc=32'h80000008.
REQ-027 Scenario 3 (back-pressure and branch): imem_ready held low 5 cycles -> pc and imem_addr stable, no retire. Then BEQ x0,x0,+16 -> pc=32'h80000010.
REQ-028 Scenario 4 (JALR): JALR x1,x5,3 with x5=32'h80000100 -> pc=32'h80000102 -> trap on the misaligned target, illegal=1, x1 unchanged. A separate run with imm=1 -> pc=32'h80000100, x1=old pc+4.
REQ-029 Scenario 5 (RV32E limit): NREG=16, ADDI x20,x0,1 -> illegal=1, halted=1, no retire. Then EBREAK on a fresh run -> halted=1, illegal=0, imem_req stays 0.
REQ-030 Scenario 6 SHALL check that reset asserted in EXEC of ADDI x3,x0,7 leaves x3=0, and that the next fetch is to RESET_PC.
